// File: rtl/text_buffer_ctrl.sv
// 16x16 text-cell buffer: single-port RAM shared between the renderer (active video),
// two round-robin write requesters and a full-screen clear engine (vertical blanking only).
module text_buffer_ctrl #(
  parameter logic [6:0] CLEAR_CHAR = 7'h20,
  parameter int         CELLS      = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [6:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [6:0] req1_data,
  output logic       req1_ready,
  input  logic       clr_start,
  output logic       busy,
  output logic       text_en
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic       cleared_once_q, cleared_once_d;
  logic       text_en_q, text_en_d;
  logic [6:0] char_code_q;
  logic [6:0] mem_q [CELLS];

  logic       arb_ok_s;
  logic       grant0_s;
  logic       grant1_s;
  logic       wr_en_s;
  logic [7:0] wr_addr_s;
  logic [6:0] wr_data_s;

  // Next-state, arbitration and the single RAM write port.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    cleared_once_d = cleared_once_q;
    wr_en_s        = 1'b0;
    wr_addr_s      = 8'h00;
    wr_data_s      = 7'h00;
    // Grants are held off during reset so no write can sneak in on a reset edge.
    arb_ok_s  = rst & (state_q == IDLE) & vblank & ~clr_start;
    grant0_s  = arb_ok_s & req0_valid & (~req1_valid | ~ptr_q);
    grant1_s  = arb_ok_s & req1_valid & (~req0_valid | ptr_q);
    text_en_d = cleared_once_q & (state_q != CLEAR);
    case (state_q)
      IDLE: begin
        cnt_d = 8'h00;
        if (clr_start) begin
          state_d = CLEAR;
        end else if (grant0_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = req0_addr;
          wr_data_s = req0_data;
          ptr_d     = 1'b1;
        end else if (grant1_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = req1_addr;
          wr_data_s = req1_data;
          ptr_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (vblank) begin
          wr_en_s   = rst;
          wr_addr_s = cnt_q;
          wr_data_s = CLEAR_CHAR;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            state_d        = IDLE;
            cleared_once_d = 1'b1;
          end else begin
            state_d = CLEAR;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers and the renderer read path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'h00;
      ptr_q          <= 1'b0;
      cleared_once_q <= 1'b0;
      text_en_q      <= 1'b0;
      char_code_q    <= 7'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      cleared_once_q <= cleared_once_d;
      text_en_q      <= text_en_d;
      if (!vblank) begin
        char_code_q <= mem_q[char_xy];
      end
    end
  end

  // Text RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign char_code  = char_code_q;
  assign busy       = (state_q == CLEAR);
  assign text_en    = text_en_q;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: reference cell model plus a read scoreboard.
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblank;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_addr, req1_addr;
  logic [6:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       clr_start;
  logic       busy;
  logic       text_en;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_cyc;
  logic       bad;
  logic [6:0] model_mem [256];
  logic [6:0] exp_q [$];

  always #5 clk = ~clk;

  text_buffer_ctrl dut (
    .clk(clk), .rst(rst), .vblank(vblank), .char_xy(char_xy), .char_code(char_code),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_start(clr_start), .busy(busy), .text_en(text_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic read_cell(input logic [7:0] a);
    logic [6:0] e;
    vblank  = 1'b0;
    char_xy = a;
    exp_q.push_back(model_mem[a]);
    tick();
    e = exp_q.pop_front();
    check_val($sformatf("rd_%0h", a), 32'(char_code), 32'(e));
  endtask

  task automatic read_all();
    for (int i = 0; i < 256; i++) read_cell(8'(i));
  endtask

  task automatic fill_model(input logic [6:0] v);
    for (int i = 0; i < 256; i++) model_mem[i] = v;
  endtask

  task automatic write_one(input logic which, input logic [7:0] a, input logic [6:0] d);
    vblank = 1'b1;
    if (which) begin
      req1_valid = 1'b1; req1_addr = a; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_addr = a; req0_data = d;
    end
    #1;
    check_val("wr_ready", {30'd0, req1_ready, req0_ready}, which ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_clear();
    vblank    = 1'b1;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check_val("busy_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy === 1'b1 && n < 2000);
  endtask

  initial begin
    rst = 1'b0; vblank = 1'b1; char_xy = 8'h00; clr_start = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h00; req0_data = 7'h00;
    req1_valid = 1'b1; req1_addr = 8'h00; req1_data = 7'h00;
    fill_model(7'h00);

    // Reset state
    #1;
    check_val("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick(); tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_text_en", 32'(text_en), 32'd0);
    check_val("rst_char_code", 32'(char_code), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Full clear with vblank held high
    start_clear();
    check_val("te_during", 32'(text_en), 32'd0);
    wait_clear(n_cyc);
    check_val("clr_cycles", 32'(n_cyc), 32'd256);
    check_val("te_at_done", 32'(text_en), 32'd0);
    tick();
    check_val("te_after", 32'(text_en), 32'd1);
    fill_model(7'h20);
    read_all();

    // Both requesters valid, pointer at requester 0
    vblank = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'h00; req0_data = 7'h41;
    req1_valid = 1'b1; req1_addr = 8'h01; req1_data = 7'h42;
    #1;
    check_val("rr_first", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    check_val("rr_second", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    req1_valid = 1'b0;
    model_mem[8'h00] = 7'h41;
    model_mem[8'h01] = 7'h42;
    read_cell(8'h00);
    read_cell(8'h01);

    // Request held through active video, granted on first vblank cycle
    vblank = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h10; req0_data = 7'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("hold_ready", 32'(req0_ready), 32'd0);
      tick();
    end
    vblank = 1'b1;
    #1;
    check_val("hold_grant", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    model_mem[8'h10] = 7'h55;
    read_cell(8'h10);

    // Lone requester wins although the pointer now favours requester 1
    write_one(1'b0, 8'h11, 7'h66);
    read_cell(8'h11);

    // clr_start coincident with a request
    vblank = 1'b1;
    clr_start = 1'b1;
    req1_valid = 1'b1; req1_addr = 8'h20; req1_data = 7'h77;
    #1;
    check_val("clr_vs_req", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    clr_start = 1'b0;
    check_val("clr_vs_req_busy", 32'(busy), 32'd1);
    bad = 1'b0;
    n_cyc = 0;
    while (busy === 1'b1 && n_cyc < 2000) begin
      if (req1_ready !== 1'b0) bad = 1'b1;
      tick();
      n_cyc++;
    end
    check_val("no_grant_in_clear", 32'(bad), 32'd0);
    check_val("clr_vs_req_done", 32'(busy), 32'd0);
    check_val("grant_after_clear", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    fill_model(7'h20);
    model_mem[8'h20] = 7'h77;
    read_cell(8'h20);
    read_cell(8'h21);

    // Clear paused by active video after 100 writes
    write_one(1'b0, 8'd50, 7'h01);
    write_one(1'b0, 8'd99, 7'h02);
    write_one(1'b0, 8'd100, 7'h03);
    write_one(1'b0, 8'd255, 7'h04);
    start_clear();
    check_val("te_enter", 32'(text_en), 32'd1);
    tick();
    check_val("te_fall", 32'(text_en), 32'd0);
    repeat (99) tick();
    for (int i = 0; i < 100; i++) model_mem[i] = 7'h20;
    read_cell(8'd99);
    read_cell(8'd100);
    read_cell(8'd255);
    read_cell(8'd50);
    check_val("pause_busy", 32'(busy), 32'd1);
    vblank = 1'b1;
    wait_clear(n_cyc);
    check_val("resume_cycles", 32'(n_cyc), 32'd156);
    fill_model(7'h20);
    read_all();

    // Reset in the middle of a clear
    write_one(1'b0, 8'd200, 7'h09);
    start_clear();
    repeat (50) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_text_en", 32'(text_en), 32'd0);
    check_val("midrst_char_code", 32'(char_code), 32'd0);
    read_cell(8'd200);
    read_cell(8'd10);
    start_clear();
    wait_clear(n_cyc);
    check_val("restart_cycles", 32'(n_cyc), 32'd256);
    check_val("restart_te0", 32'(text_en), 32'd0);
    tick();
    check_val("restart_te1", 32'(text_en), 32'd1);
    fill_model(7'h20);
    read_cell(8'd200);
    read_cell(8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
